alarm_ctrl: RTL and testbench

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/chasy_pkg.sv | 28 ++
 rtl/bcd_inc.sv | 20 ++
 rtl/alarm_ctrl.sv | 152 +++++++++++++++
 tb/tb_alarm_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chasy_pkg.sv
// Shared definitions for the alarm block: FSM states, display-mode and BCD limits.
// The SNOOZE state only exists when ALARM_SNOOZE_EN is defined.
package chasy_pkg;

    localparam logic [1:0]  REZHIM_ALARM = 2'd3;
    localparam int          BCD_W        = 4;
    localparam logic [7:0]  HOUR_MAX     = 8'h23;
    localparam logic [7:0]  MIN_MAX      = 8'h59;
    localparam logic [23:0] ALARM_RESET  = 24'h070000;

    localparam logic [1:0]  SETUP_NONE   = 2'd0;
    localparam logic [1:0]  SETUP_HOURS  = 2'd1;
    localparam logic [1:0]  SETUP_MINS   = 2'd2;

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_e;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1
    } alarm_state_e;
`endif

endpackage

// File: rtl/bcd_inc.sv
// Two-digit BCD increment that wraps to 00 once the value reaches LIMIT.
module bcd_inc import chasy_pkg::*; #(
    parameter logic [7:0] LIMIT = 8'h99
) (
    input  logic [7:0] value_i,
    output logic [7:0] value_o
);

    always_comb begin
        value_o = value_i;
        if (value_i == LIMIT) begin
            value_o = 8'h00;
        end else if (value_i[BCD_W-1:0] == 4'h9) begin
            value_o = {value_i[7:BCD_W] + 4'h1, 4'h0};
        end else begin
            value_o = {value_i[7:BCD_W], value_i[BCD_W-1:0] + 4'h1};
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm-time editing, arm/disarm, ringing with auto-stop.
// Define ALARM_SNOOZE_EN to add the SNOOZE state; otherwise snooze acts as stop.
module alarm_ctrl import chasy_pkg::*; #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data_ch,
    input  logic [1:0]  rezhim,
    input  logic [3:0]  button,
    output logic [23:0] data_a,
    output logic [1:0]  setup_rezhim_a,
    output logic        armed,
    output logic        ring
);

    localparam int RING_W = $clog2(RING_SECONDS + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECONDS - 1);
`ifdef ALARM_SNOOZE_EN
    localparam int SNOOZE_W = $clog2(SNOOZE_SECONDS + 1);
    localparam logic [SNOOZE_W-1:0] SNOOZE_LAST = SNOOZE_W'(SNOOZE_SECONDS - 1);

    logic [SNOOZE_W-1:0] snoozeCnt_q, snoozeCnt_d;
`endif

    alarm_state_e      state_q, state_d;
    logic [RING_W-1:0] ringCnt_q, ringCnt_d;
    logic [7:0]        hours_q, hours_d, mins_q, mins_d;
    logic [7:0]        hoursInc, minsInc;
    logic [1:0]        setup_q, setup_d;
    logic              armed_q, armed_d;
    logic              ring_q;
    logic [3:0]        secPrev_q;
    logic              tick, match, editing;
    logic              unusedButton;

    assign unusedButton = button[0];

    bcd_inc #(.LIMIT(HOUR_MAX)) hoursIncInst (.value_i(hours_q), .value_o(hoursInc));
    bcd_inc #(.LIMIT(MIN_MAX))  minsIncInst  (.value_i(mins_q),  .value_o(minsInc));

    assign tick    = (data_ch[3:0] != secPrev_q);
    assign match   = armed_q && (data_ch[23:8] == {hours_q, mins_q}) && (data_ch[7:0] == 8'h00);
    assign editing = (rezhim == REZHIM_ALARM) && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        ringCnt_d = ringCnt_q;
        hours_d   = hours_q;
        mins_d    = mins_q;
        armed_d   = armed_q;
        setup_d   = editing ? setup_q : SETUP_NONE;
`ifdef ALARM_SNOOZE_EN
        snoozeCnt_d = snoozeCnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (tick && match) begin
                    state_d   = RINGING;
                    ringCnt_d = '0;
                end
            end
            RINGING: begin
                if (button[1]) begin
                    state_d = IDLE;
                end else if (button[3]) begin
`ifdef ALARM_SNOOZE_EN
                    state_d     = SNOOZE;
                    snoozeCnt_d = '0;
`else
                    state_d = IDLE;
`endif
                end else if (tick) begin
                    if (ringCnt_q == RING_LAST) begin
                        state_d = IDLE;
                    end else begin
                        ringCnt_d = ringCnt_q + 1'b1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                // arm/snooze button while snoozing disarms the alarm entirely
                if (button[3]) begin
                    armed_d = 1'b0;
                    state_d = IDLE;
                end else if (tick) begin
                    if (snoozeCnt_q == SNOOZE_LAST) begin
                        state_d   = RINGING;
                        ringCnt_d = '0;
                    end else begin
                        snoozeCnt_d = snoozeCnt_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (editing) begin
            if (button[1]) begin
                setup_d = (setup_q == SETUP_MINS) ? SETUP_NONE : setup_q + 2'd1;
            end else if (button[3]) begin
                if (setup_q == SETUP_NONE) begin
                    armed_d = ~armed_q;
                end
            end else if (button[2]) begin
                if (setup_q == SETUP_HOURS) begin
                    hours_d = hoursInc;
                end else if (setup_q == SETUP_MINS) begin
                    mins_d = minsInc;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ringCnt_q <= '0;
            hours_q   <= ALARM_RESET[23:16];
            mins_q    <= ALARM_RESET[15:8];
            setup_q   <= SETUP_NONE;
            armed_q   <= 1'b0;
            ring_q    <= 1'b0;
            secPrev_q <= data_ch[3:0];
`ifdef ALARM_SNOOZE_EN
            snoozeCnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ringCnt_q <= ringCnt_d;
            hours_q   <= hours_d;
            mins_q    <= mins_d;
            setup_q   <= setup_d;
            armed_q   <= armed_d;
            ring_q    <= (state_d == RINGING);
            secPrev_q <= data_ch[3:0];
`ifdef ALARM_SNOOZE_EN
            snoozeCnt_q <= snoozeCnt_d;
`endif
        end
    end

    assign data_a         = {hours_q, mins_q, 8'h00};
    assign setup_rezhim_a = editing ? setup_q : SETUP_NONE;
    assign armed          = armed_q;
    assign ring           = ring_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl; expected alarm settings are tracked as plain
// decimal hours/minutes and ringing expectations come from tick counts.
module tb_alarm_ctrl;

    localparam int RING   = 60;
    localparam int SNOOZE = 300;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] data_ch = 24'h0;
    logic [1:0]  rezhim = 2'd0;
    logic [3:0]  button = 4'h0;
    logic [23:0] data_a;
    logic [1:0]  setup_rezhim_a;
    logic        armed;
    logic        ring;

    int tests = 0;
    int fails = 0;
    int curSec = 0;
    int mH = 7;
    int mM = 0;
    int mSetup = 0;
    bit mArmed = 1'b0;

    alarm_ctrl dut (
        .clock(clock), .reset(reset), .data_ch(data_ch), .rezhim(rezhim), .button(button),
        .data_a(data_a), .setup_rezhim_a(setup_rezhim_a), .armed(armed), .ring(ring)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] toBcd(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [23:0] expAlarm();
        return {toBcd(mH), toBcd(mM), 8'h00};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setClock(int t);
        curSec  = (t + 86400) % 86400;
        data_ch = {toBcd(curSec / 3600), toBcd((curSec / 60) % 60), toBcd(curSec % 60)};
    endtask

    task automatic advance();
        setClock(curSec + 1);
        step();
    endtask

    task automatic pulse(logic [3:0] b);
        button = b;
        step();
        button = 4'h0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mH = 7; mM = 0; mArmed = 1'b0; mSetup = 0;
    endtask

    task automatic setAlarm(int h, int m);
        rezhim = 2'd3;
        pulse(4'b0010);
        repeat ((h - mH + 24) % 24) pulse(4'b0100);
        pulse(4'b0010);
        repeat ((m - mM + 60) % 60) pulse(4'b0100);
        pulse(4'b0010);
        rezhim = 2'd0;
        mH = h; mM = m;
    endtask

    task automatic setArmed(bit a);
        if (mArmed != a) begin
            rezhim = 2'd3;
            pulse(4'b1000);
            rezhim = 2'd0;
            mArmed = a;
        end
    endtask

    task automatic test_reset();
        setClock(int'($urandom_range(0, 86399)));
        rezhim = 2'd0;
        button = 4'h0;
        reset  = 1'b1;
        step();
        step();
        tests++;
        if (data_a !== 24'h070000 || armed !== 1'b0 || ring !== 1'b0 || setup_rezhim_a !== 2'd0) begin
            fails++;
            $display("[TB] FAIL reset: data_a=%h armed=%b ring=%b setup=%0d, want 070000/0/0/0",
                     data_a, armed, ring, setup_rezhim_a);
        end
        reset = 1'b0;
        mH = 7; mM = 0; mArmed = 1'b0; mSetup = 0;
        step();
        tests++;
        if (ring !== 1'b0 || data_a !== 24'h070000) begin
            fails++;
            $display("[TB] FAIL post_reset: ring=%b data_a=%h, want 0/070000", ring, data_a);
        end
    endtask

    task automatic test_edit_random();
        logic [3:0] b;
        setClock(12 * 3600 + 34 * 60 + 56);
        rezhim = 2'd3;
        step();
        for (int i = 0; i < 80; i++) begin
            b = 4'($urandom_range(0, 15)) & 4'b1110;
            pulse(b);
            if (b[1]) mSetup = (mSetup + 1) % 3;
            else if (b[3]) begin
                if (mSetup == 0) mArmed = !mArmed;
            end else if (b[2]) begin
                if (mSetup == 1) mH = (mH + 1) % 24;
                else if (mSetup == 2) mM = (mM + 1) % 60;
            end
            tests++;
            if (data_a !== expAlarm() || setup_rezhim_a !== 2'(mSetup) || armed !== mArmed) begin
                fails++;
                $display("[TB] FAIL edit_random[%0d] btn=%b: data_a=%h setup=%0d armed=%b, want %h/%0d/%b",
                         i, b, data_a, setup_rezhim_a, armed, expAlarm(), mSetup, mArmed);
            end
        end
        if (mSetup == 0) begin
            pulse(4'b0010);
            mSetup = 1;
        end
        rezhim = 2'd0;
        step();
        mSetup = 0;
        tests++;
        if (setup_rezhim_a !== 2'd0 || data_a !== expAlarm()) begin
            fails++;
            $display("[TB] FAIL leave_mode: setup=%0d data_a=%h, want 0/%h", setup_rezhim_a, data_a, expAlarm());
        end
    endtask

    task automatic test_bcd_wrap();
        doReset();
        rezhim = 2'd3;
        pulse(4'b0010);
        repeat (24) pulse(4'b0100);
        tests++;
        if (data_a !== 24'h070000 || setup_rezhim_a !== 2'd1) begin
            fails++;
            $display("[TB] FAIL hours_wrap: data_a=%h setup=%0d, want 070000/1", data_a, setup_rezhim_a);
        end
        pulse(4'b0010);
        repeat (58) pulse(4'b0100);
        tests++;
        if (data_a !== 24'h075800) begin
            fails++;
            $display("[TB] FAIL mins_58: data_a=%h, want 075800", data_a);
        end
        repeat (2) pulse(4'b0100);
        tests++;
        if (data_a !== 24'h070000) begin
            fails++;
            $display("[TB] FAIL mins_wrap: data_a=%h, want 070000", data_a);
        end
        pulse(4'b0010);
        tests++;
        if (setup_rezhim_a !== 2'd0) begin
            fails++;
            $display("[TB] FAIL setup_cycle: setup=%0d, want 0", setup_rezhim_a);
        end
        rezhim = 2'd0;
    endtask

    task automatic test_priority();
        logic [3:0] combos [5] = '{4'b0110, 4'b0110, 4'b1100, 4'b0010, 4'b1010};
        int         expSetup [5] = '{1, 2, 2, 0, 1};
        rezhim = 2'd3;
        step();
        for (int i = 0; i < 5; i++) begin
            pulse(combos[i]);
            tests++;
            if (setup_rezhim_a !== 2'(expSetup[i]) || data_a !== 24'h070000 || armed !== 1'b0) begin
                fails++;
                $display("[TB] FAIL priority[%0d] btn=%b: setup=%0d data_a=%h armed=%b, want %0d/070000/0",
                         i, combos[i], setup_rezhim_a, data_a, armed, expSetup[i]);
            end
        end
        pulse(4'b0010);
        pulse(4'b0010);
        rezhim = 2'd0;
        mSetup = 0;
    endtask

    task automatic test_ring_timeout();
        doReset();
        setArmed(1'b1);
        setClock(6 * 3600 + 59 * 60 + 59);
        step();
        step();
        tests++;
        if (ring !== 1'b0 || armed !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pre_ring: ring=%b armed=%b, want 0/1", ring, armed);
        end
        setClock(7 * 3600);
        step();
        tests++;
        if (ring !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ring_start: ring=%b, want 1", ring);
        end
        for (int i = 1; i <= RING; i++) begin
            advance();
            tests++;
            if (ring !== (i < RING)) begin
                fails++;
                $display("[TB] FAIL ring_timeout tick %0d: ring=%b, want %b", i, ring, i < RING);
            end
        end
        tests++;
        if (armed !== 1'b1) begin
            fails++;
            $display("[TB] FAIL armed_after_timeout: armed=%b, want 1", armed);
        end
    endtask

    task automatic test_snooze();
        bit expRing;
        setClock(6 * 3600 + 59 * 60 + 59);
        step();
        setClock(7 * 3600);
        step();
        tests++;
        if (ring !== 1'b1) begin
            fails++;
            $display("[TB] FAIL snooze_ring_start: ring=%b, want 1", ring);
        end
        pulse(4'b1000);
        tests++;
        if (ring !== 1'b0) begin
            fails++;
            $display("[TB] FAIL snooze_press: ring=%b, want 0", ring);
        end
        for (int i = 1; i <= SNOOZE; i++) begin
            advance();
`ifdef ALARM_SNOOZE_EN
            expRing = (i == SNOOZE);
`else
            expRing = 1'b0;
`endif
            tests++;
            if (ring !== expRing) begin
                fails++;
                $display("[TB] FAIL snooze tick %0d: ring=%b, want %b", i, ring, expRing);
            end
        end
        pulse(4'b0010);
        tests++;
        if (ring !== 1'b0 || armed !== 1'b1) begin
            fails++;
            $display("[TB] FAIL snooze_end: ring=%b armed=%b, want 0/1", ring, armed);
        end
    endtask

    task automatic test_disarmed_and_reset();
        int h, m;
        setArmed(1'b0);
        setClock(6 * 3600 + 59 * 60 + 59);
        step();
        setClock(7 * 3600);
        step();
        advance();
        tests++;
        if (ring !== 1'b0) begin
            fails++;
            $display("[TB] FAIL disarmed_ring: ring=%b, want 0", ring);
        end
        for (int it = 0; it < 3; it++) begin
            h = int'($urandom_range(0, 23));
            m = int'($urandom_range(0, 59));
            setAlarm(h, m);
            setArmed(1'b1);
            setClock(h * 3600 + m * 60 - 1);
            step();
            tests++;
            if (ring !== 1'b0 || data_a !== expAlarm() || armed !== 1'b1) begin
                fails++;
                $display("[TB] FAIL random_setup[%0d]: ring=%b data_a=%h armed=%b, want 0/%h/1",
                         it, ring, data_a, armed, expAlarm());
            end
            setClock(h * 3600 + m * 60);
            step();
            tests++;
            if (ring !== 1'b1) begin
                fails++;
                $display("[TB] FAIL random_ring[%0d] at %h: ring=%b, want 1", it, data_ch, ring);
            end
            rezhim = 2'd3;
            pulse(4'b0100);
            tests++;
            if (ring !== 1'b1 || data_a !== expAlarm() || setup_rezhim_a !== 2'd0) begin
                fails++;
                $display("[TB] FAIL edit_locked[%0d]: ring=%b data_a=%h setup=%0d, want 1/%h/0",
                         it, ring, data_a, setup_rezhim_a, expAlarm());
            end
            if (it < 2) begin
                pulse(4'b0010);
                rezhim = 2'd0;
                tests++;
                if (ring !== 1'b0 || armed !== 1'b1 || setup_rezhim_a !== 2'd0) begin
                    fails++;
                    $display("[TB] FAIL stop[%0d]: ring=%b armed=%b setup=%0d, want 0/1/0",
                             it, ring, armed, setup_rezhim_a);
                end
            end else begin
                rezhim = 2'd0;
                doReset();
                tests++;
                if (ring !== 1'b0 || data_a !== 24'h070000 || armed !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL reset_in_ring: ring=%b data_a=%h armed=%b, want 0/070000/0",
                             ring, data_a, armed);
                end
            end
        end
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_edit_random();
        test_bcd_wrap();
        test_priority();
        test_ring_timeout();
        test_snooze();
        test_disarmed_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
